checkout_sequencer: RTL and testbench
=====================================

// Module: checkout_sequencer
// PURPOSE
//  Parametrised sale-terminal sequencer: barcode entry, quantity selection, basket-edit cursor, checkout confirm.
//  Owns the barcode digit shift register and an inactivity timeout.
//  Consumes debounced one-cycle key/command pulses and a combinational barcode->product lookup.
//  Drives one-cycle add/remove/checkout/error pulses to the basket controller and its state to the LED controller.
// PARAMETERS
//  NUM_KEYS      4    digit/direction keys; key i encodes digit NUM_KEYS-i
//  DIGIT_W       4    bits per barcode digit
//  BC_DIGITS     4    barcode length in digits (>=1)
//  ID_W          4    product ID width
//  QTY_MAX       4    largest accepted quantity (<=NUM_KEYS)
//  CNT_W         4    basket item count / cursor width
//  TIMEOUT_CYC   0    inactivity abort in cycles; 0 = disabled
// PORTS
//  CLOCK_50       in   1                   clock
//  RESET_N        in   1                   async reset, active low
//  key_pulse      in   NUM_KEYS            one-cycle key presses
//  cmd_select     in   1                   select pulse
//  cmd_cancel     in   1                   cancel pulse
//  cmd_end        in   1                   end-shopping pulse
//  edit_sw        in   1                   level; 1 = basket-edit mode
//  lookup_valid   in   1                   barcode_out maps to a product (comb.)
//  lookup_id      in   ID_W                product ID for barcode_out
//  basket_count   in   CNT_W               items currently in basket
//  barcode_out    out  BC_DIGITS*DIGIT_W   digits, newest in [DIGIT_W-1:0]
//  digits_entered out  $clog2(BC_DIGITS+1) digits held
//  state_out      out  3                   current state code
//  add_pulse      out  1                   add add_id x add_qty
//  add_id         out  ID_W                held until next add
//  add_qty        out  $clog2(QTY_MAX+1)   held until next add
//  remove_pulse   out  1                   remove item at cursor
//  cursor         out  CNT_W               basket-edit cursor
//  checkout_pulse out  1                   shopping finished
//  error_pulse    out  1                   invalid barcode / qty / timeout / empty checkout
// BEHAVIOUR
//  Reset (async, RESET_N=0): state IDLE, all outputs 0, barcode register and timer cleared.
//  Outputs registered; each pulse is 1 cycle, asserted the cycle after the triggering input.
//  Key press is valid only if exactly one key_pulse bit is set; multi-bit presses are ignored.
//  Same-cycle priority: cmd_cancel > cmd_end > cmd_select > key.
//  States (state_out):
//   IDLE=0    edit_sw=1 -> EDIT (cursor<=0). Else valid key -> shift digit in, -> BARCODE.
//   BARCODE=1 valid key while digits_entered<BC_DIGITS -> shift in, count+1; keys at full count ignored.
//             cancel -> clear register, -> IDLE.
//             select at full count: lookup_valid -> latch add_id=lookup_id, -> QTY;
//               else error_pulse, clear, -> IDLE.
//             select below full count: ignored.  edit_sw rising -> clear, -> EDIT.
//   QTY=2     valid key i: q=NUM_KEYS-i; q<=QTY_MAX -> add_qty=q, add_pulse, clear barcode, -> IDLE;
//               else error_pulse, stay QTY.  cancel -> clear, -> IDLE.
//   EDIT=3    key[NUM_KEYS-2]=down: cursor+1, saturates at basket_count-1.  key[1]=up: cursor-1, saturates at 0.
//             select with basket_count>0 -> remove_pulse; cursor stays, clamped to new count-1 if beyond.
//             edit_sw=0 -> cursor<=0, -> IDLE.
//   END=4     any non-EDIT state, cmd_end.  basket_count==0 -> error_pulse, -> IDLE.
//             Otherwise wait: cmd_end -> checkout_pulse, clear all, -> IDLE; cancel -> IDLE.
//  Timeout: counter reloads on any key/cmd.  In BARCODE, QTY or END, reaching TIMEOUT_CYC idle cycles
//   -> error_pulse, clear barcode, -> IDLE.  Disabled when TIMEOUT_CYC=0.
//  cmd_end is ignored in EDIT.  Unused state codes -> IDLE.
// TESTING
//  Defaults; keys 3,2,1,0 (digits 1,2,3,4), lookup_valid=1, lookup_id=7, select, key 2 (qty 2)
//    -> barcode_out=16'h1234, add_pulse once, add_id=7, add_qty=2, state 0.
//  Four digits with lookup_valid=0, select -> error_pulse, barcode_out=0, state 0.
//  Two digits, then 5th key after four digits -> 5th ignored; cancel mid-entry -> state 0, digits_entered=0.
//  TIMEOUT_CYC=100, one digit then idle 100 cycles -> error_pulse at cycle 100, state 0; key at cycle 99 reloads timer.
//  basket_count=3, edit_sw=1, down x4 -> cursor 2 (saturated); select -> remove_pulse; basket_count->2 -> cursor 1.
//  cmd_end with basket_count=0 -> error_pulse; with 2 -> state 4, second cmd_end -> checkout_pulse; RESET_N low mid-BARCODE -> all outputs 0 immediately.

Source files
------------

// File: rtl/checkout_sequencer.sv
// checkout_sequencer
//   Sale-terminal sequencer: barcode entry, quantity pick, basket-edit cursor
//   and checkout confirm. Owns the barcode digit shift register and an
//   inactivity timer; all outputs are registered, pulses last one cycle.
// Ports
//   CLOCK_50, RESET_N          clock, async active-low reset
//   key_pulse[NUM_KEYS]        one-cycle key presses (key i = digit NUM_KEYS-i)
//   cmd_select/cancel/end      one-cycle command pulses
//   edit_sw                    level, 1 = basket-edit mode
//   lookup_valid, lookup_id    combinational product lookup of barcode_out
//   basket_count               items in basket
//   barcode_out, digits_entered  shift register (newest digit in LSBs), fill
//   state_out                  IDLE=0 BARCODE=1 QTY=2 EDIT=3 END=4
//   add_pulse/add_id/add_qty   add request (id/qty held until next add)
//   remove_pulse, cursor       basket-edit remove request and cursor
//   checkout_pulse, error_pulse
module checkout_sequencer #(
    parameter int NUM_KEYS    = 4,
    parameter int DIGIT_W     = 4,
    parameter int BC_DIGITS   = 4,
    parameter int ID_W        = 4,
    parameter int QTY_MAX     = 4,
    parameter int CNT_W       = 4,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                           CLOCK_50,
    input  logic                           RESET_N,
    input  logic [NUM_KEYS-1:0]            key_pulse,
    input  logic                           cmd_select,
    input  logic                           cmd_cancel,
    input  logic                           cmd_end,
    input  logic                           edit_sw,
    input  logic                           lookup_valid,
    input  logic [ID_W-1:0]                lookup_id,
    input  logic [CNT_W-1:0]               basket_count,
    output logic [BC_DIGITS*DIGIT_W-1:0]   barcode_out,
    output logic [$clog2(BC_DIGITS+1)-1:0] digits_entered,
    output logic [2:0]                     state_out,
    output logic                           add_pulse,
    output logic [ID_W-1:0]                add_id,
    output logic [$clog2(QTY_MAX+1)-1:0]   add_qty,
    output logic                           remove_pulse,
    output logic [CNT_W-1:0]               cursor,
    output logic                           checkout_pulse,
    output logic                           error_pulse
);
    localparam int BCW = BC_DIGITS * DIGIT_W;
    localparam int DEW = $clog2(BC_DIGITS + 1);
    localparam int QW  = $clog2(QTY_MAX + 1);
    localparam int TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int TMO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [DEW-1:0] BC_FULL = DEW'(BC_DIGITS);
    localparam logic [TW-1:0]  TMO_LV  = TW'(TMO_LAST);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_BARCODE = 3'd1, S_QTY = 3'd2, S_EDIT = 3'd3, S_END = 3'd4
    } state_t;

    state_t           r_state, w_state;
    logic [BCW-1:0]   r_bc, w_bc;
    logic [DEW-1:0]   r_cnt, w_cnt;
    logic [ID_W-1:0]  r_add_id, w_add_id;
    logic [QW-1:0]    r_add_qty, w_add_qty;
    logic [CNT_W-1:0] r_cursor, w_cursor;
    logic             r_add_p, w_add_p, r_rem_p, w_rem_p;
    logic             r_chk_p, w_chk_p, r_err_p, w_err_p;
    logic [TW-1:0]    r_tmr, w_tmr;
    logic             r_edit_d;

    // Key decode: only a single set bit counts as a press.
    logic               w_key_vld, w_qty_ok, w_down, w_up;
    logic [DIGIT_W-1:0] w_digit;
    logic [QW-1:0]      w_qty;
    always_comb begin
        w_digit  = '0;
        w_qty    = '0;
        w_qty_ok = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_pulse[i]) begin
                w_digit  = DIGIT_W'(NUM_KEYS - i);
                w_qty    = QW'(NUM_KEYS - i);
                w_qty_ok = (NUM_KEYS - i) <= QTY_MAX;
            end
        end
    end
    assign w_key_vld = $onehot(key_pulse);
    assign w_down    = w_key_vld && key_pulse[NUM_KEYS-2];
    assign w_up      = w_key_vld && key_pulse[1];

    logic [BCW-1:0] w_shift;
    assign w_shift = (r_bc << DIGIT_W) | BCW'(w_digit);

    logic w_activity, w_timed, w_tmo, w_edit_rise, w_full;
    assign w_activity  = (|key_pulse) | cmd_select | cmd_cancel | cmd_end;
    assign w_timed     = (r_state == S_BARCODE) || (r_state == S_QTY) || (r_state == S_END);
    assign w_tmo       = (TIMEOUT_CYC != 0) && w_timed && !w_activity && (r_tmr == TMO_LV);
    assign w_edit_rise = edit_sw && !r_edit_d;
    assign w_full      = (r_cnt == BC_FULL);

    // Cursor helpers: wider compare so basket_count-1 never wraps.
    logic [CNT_W:0]   w_cur_p1;
    logic [CNT_W-1:0] w_cur_max;
    assign w_cur_p1  = {1'b0, r_cursor} + (CNT_W+1)'(1);
    assign w_cur_max = (basket_count == '0) ? '0 : basket_count - CNT_W'(1);

    assign w_tmr = (!w_timed || w_activity || w_tmo) ? '0 : r_tmr + TW'(1);

    always_comb begin
        w_state   = r_state;
        w_bc      = r_bc;
        w_cnt     = r_cnt;
        w_add_id  = r_add_id;
        w_add_qty = r_add_qty;
        w_cursor  = r_cursor;
        w_add_p   = 1'b0;
        w_rem_p   = 1'b0;
        w_chk_p   = 1'b0;
        w_err_p   = 1'b0;
        // cmd_end from a non-EDIT, non-END state: empty basket is an error.
        if (cmd_end && !cmd_cancel && r_state != S_EDIT && r_state != S_END) begin
            if (basket_count == '0) begin
                w_err_p = 1'b1;
                w_bc    = '0;
                w_cnt   = '0;
                w_state = S_IDLE;
            end else begin
                w_state = S_END;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (edit_sw) begin
                        w_cursor = '0;
                        w_state  = S_EDIT;
                    end else if (w_key_vld) begin
                        w_bc    = w_shift;
                        w_cnt   = DEW'(1);
                        w_state = S_BARCODE;
                    end
                end
                S_BARCODE: begin
                    if (cmd_cancel) begin
                        w_bc    = '0;
                        w_cnt   = '0;
                        w_state = S_IDLE;
                    end else if (cmd_select) begin
                        if (w_full && lookup_valid) begin
                            w_add_id = lookup_id;
                            w_state  = S_QTY;
                        end else if (w_full) begin
                            w_err_p = 1'b1;
                            w_bc    = '0;
                            w_cnt   = '0;
                            w_state = S_IDLE;
                        end
                    end else if (w_edit_rise) begin
                        w_bc     = '0;
                        w_cnt    = '0;
                        w_cursor = '0;
                        w_state  = S_EDIT;
                    end else if (w_key_vld) begin
                        if (!w_full) begin
                            w_bc  = w_shift;
                            w_cnt = r_cnt + DEW'(1);
                        end
                    end else if (w_tmo) begin
                        w_err_p = 1'b1;
                        w_bc    = '0;
                        w_cnt   = '0;
                        w_state = S_IDLE;
                    end
                end
                S_QTY: begin
                    if (cmd_cancel || w_tmo) begin
                        w_err_p = w_tmo;
                        w_bc    = '0;
                        w_cnt   = '0;
                        w_state = S_IDLE;
                    end else if (!cmd_select && w_key_vld) begin
                        if (w_qty_ok) begin
                            w_add_qty = w_qty;
                            w_add_p   = 1'b1;
                            w_bc      = '0;
                            w_cnt     = '0;
                            w_state   = S_IDLE;
                        end else begin
                            w_err_p = 1'b1;
                        end
                    end
                end
                S_EDIT: begin
                    if (!edit_sw) begin
                        w_cursor = '0;
                        w_state  = S_IDLE;
                    end else if (cmd_select && basket_count != '0) begin
                        w_rem_p = 1'b1;
                    end else if (w_down) begin
                        if (w_cur_p1 < {1'b0, basket_count}) w_cursor = w_cur_p1[CNT_W-1:0];
                    end else if (w_up) begin
                        if (r_cursor != '0) w_cursor = r_cursor - CNT_W'(1);
                    end else if (r_cursor > w_cur_max) begin
                        // basket shrank (e.g. after a remove): pull cursor back in range
                        w_cursor = w_cur_max;
                    end
                end
                S_END: begin
                    if (cmd_cancel) begin
                        w_state = S_IDLE;
                    end else if (cmd_end) begin
                        w_chk_p   = 1'b1;
                        w_bc      = '0;
                        w_cnt     = '0;
                        w_add_id  = '0;
                        w_add_qty = '0;
                        w_cursor  = '0;
                        w_state   = S_IDLE;
                    end else if (w_tmo) begin
                        w_err_p = 1'b1;
                        w_bc    = '0;
                        w_cnt   = '0;
                        w_state = S_IDLE;
                    end
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= S_IDLE;
            r_bc      <= '0;
            r_cnt     <= '0;
            r_add_id  <= '0;
            r_add_qty <= '0;
            r_cursor  <= '0;
            r_add_p   <= 1'b0;
            r_rem_p   <= 1'b0;
            r_chk_p   <= 1'b0;
            r_err_p   <= 1'b0;
            r_tmr     <= '0;
            r_edit_d  <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_bc      <= w_bc;
            r_cnt     <= w_cnt;
            r_add_id  <= w_add_id;
            r_add_qty <= w_add_qty;
            r_cursor  <= w_cursor;
            r_add_p   <= w_add_p;
            r_rem_p   <= w_rem_p;
            r_chk_p   <= w_chk_p;
            r_err_p   <= w_err_p;
            r_tmr     <= w_tmr;
            r_edit_d  <= edit_sw;
        end
    end

    assign barcode_out    = r_bc;
    assign digits_entered = r_cnt;
    assign state_out      = r_state;
    assign add_pulse      = r_add_p;
    assign add_id         = r_add_id;
    assign add_qty        = r_add_qty;
    assign remove_pulse   = r_rem_p;
    assign cursor         = r_cursor;
    assign checkout_pulse = r_chk_p;
    assign error_pulse    = r_err_p;
endmodule

// File: tb/tb_checkout_sequencer.sv
// Directed bench for checkout_sequencer: a vector table on a default instance
// (timeout disabled) plus hand sequences for async reset and the inactivity
// timeout on a second instance with TIMEOUT_CYC=100.
module tb_checkout_sequencer;
    logic CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    logic       RESET_N;
    logic [3:0] key_pulse;
    logic       cmd_select, cmd_cancel, cmd_end, edit_sw, lookup_valid;
    logic [3:0] lookup_id, basket_count;

    logic [15:0] a_bc, b_bc;
    logic [2:0]  a_dig, b_dig, a_st, b_st, a_qty, b_qty;
    logic [3:0]  a_id, b_id, a_cur, b_cur;
    logic        a_add, b_add, a_rem, b_rem, a_chk, b_chk, a_err, b_err;

    checkout_sequencer dut_a (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .key_pulse(key_pulse),
        .cmd_select(cmd_select), .cmd_cancel(cmd_cancel), .cmd_end(cmd_end),
        .edit_sw(edit_sw), .lookup_valid(lookup_valid), .lookup_id(lookup_id),
        .basket_count(basket_count), .barcode_out(a_bc), .digits_entered(a_dig),
        .state_out(a_st), .add_pulse(a_add), .add_id(a_id), .add_qty(a_qty),
        .remove_pulse(a_rem), .cursor(a_cur), .checkout_pulse(a_chk), .error_pulse(a_err)
    );

    checkout_sequencer #(.TIMEOUT_CYC(100)) dut_b (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .key_pulse(key_pulse),
        .cmd_select(cmd_select), .cmd_cancel(cmd_cancel), .cmd_end(cmd_end),
        .edit_sw(edit_sw), .lookup_valid(lookup_valid), .lookup_id(lookup_id),
        .basket_count(basket_count), .barcode_out(b_bc), .digits_entered(b_dig),
        .state_out(b_st), .add_pulse(b_add), .add_id(b_id), .add_qty(b_qty),
        .remove_pulse(b_rem), .cursor(b_cur), .checkout_pulse(b_chk), .error_pulse(b_err)
    );

    logic [36:0] a_bundle, b_bundle;
    assign a_bundle = {a_bc, a_dig, a_st, a_add, a_id, a_qty, a_rem, a_cur, a_chk, a_err};
    assign b_bundle = {b_bc, b_dig, b_st, b_add, b_id, b_qty, b_rem, b_cur, b_chk, b_err};

    // cmd = {select, cancel, end, edit_sw, lookup_valid}; pul = {add, remove, checkout, error}
    typedef struct {
        logic [3:0]  key;
        logic [4:0]  cmd;
        logic [3:0]  lid;
        logic [3:0]  bcnt;
        logic [15:0] bc;
        logic [2:0]  dig;
        logic [2:0]  st;
        logic [3:0]  pul;
        logic [3:0]  id;
        logic [2:0]  qty;
        logic [3:0]  cur;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t tv[$];

    function automatic vec_t mk(logic [3:0] key, logic [4:0] cmd, logic [3:0] lid,
                                logic [3:0] bcnt, logic [15:0] bc, logic [2:0] dig,
                                logic [2:0] st, logic [3:0] pul, logic [3:0] id,
                                logic [2:0] qty, logic [3:0] cur);
        vec_t v;
        v.key = key; v.cmd = cmd; v.lid = lid; v.bcnt = bcnt; v.bc = bc; v.dig = dig;
        v.st = st; v.pul = pul; v.id = id; v.qty = qty; v.cur = cur;
        return v;
    endfunction

    function automatic logic [36:0] pk(vec_t v);
        return {v.bc, v.dig, v.st, v.pul[3], v.id, v.qty, v.pul[2], v.cur, v.pul[1], v.pul[0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        key_pulse  = '0;
        cmd_select = 1'b0;
        cmd_cancel = 1'b0;
        cmd_end    = 1'b0;
    endtask

    initial begin
        bit early;
        RESET_N = 1'b0; key_pulse = '0; cmd_select = 0; cmd_cancel = 0; cmd_end = 0;
        edit_sw = 0; lookup_valid = 1; lookup_id = 4'd7; basket_count = '0;

        //        key      cmd       lid bcnt  bc       dig st pul      id qty cur
        // full add: digits 1,2,3,4 then select, qty 2
        tv.push_back(mk(4'h8, 5'b00001, 7, 0, 16'h0001, 1, 1, 4'b0000, 0, 0, 0));
        tv.push_back(mk(4'h4, 5'b00001, 7, 0, 16'h0012, 2, 1, 4'b0000, 0, 0, 0));
        tv.push_back(mk(4'h2, 5'b00001, 7, 0, 16'h0123, 3, 1, 4'b0000, 0, 0, 0));
        tv.push_back(mk(4'h1, 5'b00001, 7, 0, 16'h1234, 4, 1, 4'b0000, 0, 0, 0));
        tv.push_back(mk(4'h0, 5'b10001, 7, 0, 16'h1234, 4, 2, 4'b0000, 7, 0, 0));
        tv.push_back(mk(4'h4, 5'b00001, 7, 0, 16'h0000, 0, 0, 4'b1000, 7, 2, 0));
        tv.push_back(mk(4'h0, 5'b00001, 7, 0, 16'h0000, 0, 0, 4'b0000, 7, 2, 0));
        // unknown barcode
        tv.push_back(mk(4'h8, 5'b00000, 7, 0, 16'h0001, 1, 1, 4'b0000, 7, 2, 0));
        tv.push_back(mk(4'h4, 5'b00000, 7, 0, 16'h0012, 2, 1, 4'b0000, 7, 2, 0));
        tv.push_back(mk(4'h2, 5'b00000, 7, 0, 16'h0123, 3, 1, 4'b0000, 7, 2, 0));
        tv.push_back(mk(4'h1, 5'b00000, 7, 0, 16'h1234, 4, 1, 4'b0000, 7, 2, 0));
        tv.push_back(mk(4'h0, 5'b10000, 7, 0, 16'h0000, 0, 0, 4'b0001, 7, 2, 0));
        tv.push_back(mk(4'h0, 5'b00001, 7, 0, 16'h0000, 0, 0, 4'b0000, 7, 2, 0));
        // 5th key ignored, select latches id 5, cancel out of QTY
        tv.push_back(mk(4'h1, 5'b00001, 7, 0, 16'h0004, 1, 1, 4'b0000, 7, 2, 0));
        tv.push_back(mk(4'h1, 5'b00001, 7, 0, 16'h0044, 2, 1, 4'b0000, 7, 2, 0));
        tv.push_back(mk(4'h2, 5'b00001, 7, 0, 16'h0443, 3, 1, 4'b0000, 7, 2, 0));
        tv.push_back(mk(4'h8, 5'b00001, 7, 0, 16'h4431, 4, 1, 4'b0000, 7, 2, 0));
        tv.push_back(mk(4'h4, 5'b00001, 7, 0, 16'h4431, 4, 1, 4'b0000, 7, 2, 0));
        tv.push_back(mk(4'h0, 5'b10001, 5, 0, 16'h4431, 4, 2, 4'b0000, 5, 2, 0));
        tv.push_back(mk(4'h0, 5'b01001, 5, 0, 16'h0000, 0, 0, 4'b0000, 5, 2, 0));
        // cancel mid-entry, multi-bit key ignored, short select ignored
        tv.push_back(mk(4'h2, 5'b00001, 7, 0, 16'h0003, 1, 1, 4'b0000, 5, 2, 0));
        tv.push_back(mk(4'h4, 5'b00001, 7, 0, 16'h0032, 2, 1, 4'b0000, 5, 2, 0));
        tv.push_back(mk(4'h0, 5'b01001, 7, 0, 16'h0000, 0, 0, 4'b0000, 5, 2, 0));
        tv.push_back(mk(4'h3, 5'b00001, 7, 0, 16'h0000, 0, 0, 4'b0000, 5, 2, 0));
        tv.push_back(mk(4'h8, 5'b00001, 7, 0, 16'h0001, 1, 1, 4'b0000, 5, 2, 0));
        tv.push_back(mk(4'h0, 5'b10001, 7, 0, 16'h0001, 1, 1, 4'b0000, 5, 2, 0));
        tv.push_back(mk(4'h0, 5'b01001, 7, 0, 16'h0000, 0, 0, 4'b0000, 5, 2, 0));
        // edit mode: down x4 saturates at 2, remove, basket shrinks -> clamp, up
        tv.push_back(mk(4'h0, 5'b00011, 7, 3, 16'h0000, 0, 3, 4'b0000, 5, 2, 0));
        tv.push_back(mk(4'h4, 5'b00011, 7, 3, 16'h0000, 0, 3, 4'b0000, 5, 2, 1));
        tv.push_back(mk(4'h4, 5'b00011, 7, 3, 16'h0000, 0, 3, 4'b0000, 5, 2, 2));
        tv.push_back(mk(4'h4, 5'b00011, 7, 3, 16'h0000, 0, 3, 4'b0000, 5, 2, 2));
        tv.push_back(mk(4'h4, 5'b00011, 7, 3, 16'h0000, 0, 3, 4'b0000, 5, 2, 2));
        tv.push_back(mk(4'h0, 5'b10011, 7, 3, 16'h0000, 0, 3, 4'b0100, 5, 2, 2));
        tv.push_back(mk(4'h0, 5'b00011, 7, 2, 16'h0000, 0, 3, 4'b0000, 5, 2, 1));
        tv.push_back(mk(4'h2, 5'b00011, 7, 2, 16'h0000, 0, 3, 4'b0000, 5, 2, 0));
        tv.push_back(mk(4'h2, 5'b00011, 7, 2, 16'h0000, 0, 3, 4'b0000, 5, 2, 0));
        tv.push_back(mk(4'h0, 5'b00111, 7, 2, 16'h0000, 0, 3, 4'b0000, 5, 2, 0));
        tv.push_back(mk(4'h0, 5'b00001, 7, 2, 16'h0000, 0, 0, 4'b0000, 5, 2, 0));
        // edit_sw rising during barcode entry
        tv.push_back(mk(4'h8, 5'b00001, 7, 2, 16'h0001, 1, 1, 4'b0000, 5, 2, 0));
        tv.push_back(mk(4'h0, 5'b00011, 7, 2, 16'h0000, 0, 3, 4'b0000, 5, 2, 0));
        tv.push_back(mk(4'h0, 5'b00001, 7, 2, 16'h0000, 0, 0, 4'b0000, 5, 2, 0));
        // end shopping: empty basket error, END wait, checkout, cancel from END
        tv.push_back(mk(4'h0, 5'b00101, 7, 0, 16'h0000, 0, 0, 4'b0001, 5, 2, 0));
        tv.push_back(mk(4'h0, 5'b00101, 7, 2, 16'h0000, 0, 4, 4'b0000, 5, 2, 0));
        tv.push_back(mk(4'h0, 5'b00001, 7, 2, 16'h0000, 0, 4, 4'b0000, 5, 2, 0));
        tv.push_back(mk(4'h0, 5'b00101, 7, 2, 16'h0000, 0, 0, 4'b0010, 0, 0, 0));
        tv.push_back(mk(4'h0, 5'b00101, 7, 2, 16'h0000, 0, 4, 4'b0000, 0, 0, 0));
        tv.push_back(mk(4'h0, 5'b01001, 7, 2, 16'h0000, 0, 0, 4'b0000, 0, 0, 0));

        #12;
        chk("reset_a", 64'(a_bundle), 64'd0);
        chk("reset_b", 64'(b_bundle), 64'd0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;

        foreach (tv[i]) begin
            key_pulse = tv[i].key;
            {cmd_select, cmd_cancel, cmd_end, edit_sw, lookup_valid} = tv[i].cmd;
            lookup_id    = tv[i].lid;
            basket_count = tv[i].bcnt;
            tick();
            chk($sformatf("vec%0d", i), 64'(a_bundle), 64'(pk(tv[i])));
        end

        // async reset in the middle of barcode entry
        key_pulse = 4'h8; tick();
        key_pulse = 4'h4; tick();
        chk("mid_bc_state", 64'(a_st), 64'd1);
        #2 RESET_N = 1'b0;
        #1 chk("rst_mid_a", 64'(a_bundle), 64'd0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;

        // first digit after reset lands in a cleared register; also starts timeout run
        key_pulse = 4'h8; tick();
        chk("post_rst_digit", 64'(a_bundle), 64'(pk(mk(0, 0, 0, 0, 16'h0001, 1, 1, 0, 0, 0, 0))));
        early = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (n < 100 && b_err) early = 1'b1;
            if (n == 99) chk("tmo_not_yet", 64'(b_err), 64'd0);
            if (n == 100) begin
                chk("tmo_err", 64'(b_err), 64'd1);
                chk("tmo_state", 64'(b_st), 64'd0);
                chk("tmo_bc_clr", 64'(b_bc), 64'd0);
                chk("no_tmo_dflt", 64'(a_st), 64'd1);
            end
        end
        chk("tmo_no_early", 64'(early), 64'd0);

        // key on the 99th idle cycle reloads the timer
        key_pulse = 4'h8; tick();
        early = 1'b0;
        for (int n = 1; n <= 199; n++) begin
            if (n == 99) key_pulse = 4'h4;
            tick();
            if (n < 199 && b_err) early = 1'b1;
            if (n == 100) begin
                chk("reload_err", 64'(b_err), 64'd0);
                chk("reload_state", 64'(b_st), 64'd1);
                chk("reload_digits", 64'(b_dig), 64'd2);
            end
            if (n == 199) chk("reload_tmo", 64'(b_err), 64'd1);
        end
        chk("reload_no_early", 64'(early), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
